// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit multiplexed 7-segment scanner with frame-synchronous data update.
// Define SEG_SCAN_BLANK_EN to blank the first BLANK_CYC cycles of each digit slot.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        load,
  input  logic [15:0] disp_data,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  digit_en,
  output logic [7:0]  seg_led,
  output logic [3:0]  seg_sel,
  output logic        frame_done
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  if (CLK_DIV < 2 || BLANK_CYC >= CLK_DIV) begin : gen_bad_params
    $error("seg_scan_ctrl: illegal CLK_DIV/BLANK_CYC combination");
  end

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            tick, wrap;

  logic [15:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [3:0]  pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [3:0]  pend_en_q, pend_en_d, act_en_q, act_en_d;

  logic [7:0] led_q, led_d;
  logic [3:0] sel_q, sel_d;
  logic       done_q, done_d;

  logic [3:0] nibble;
  logic [6:0] seg7;
  logic       blank;

  // Scan timing and frame-synchronous register update
  always_comb begin
    tick  = (cnt_q == CntMax);
    wrap  = tick && (idx_q == 2'd3);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_en_d   = pend_en_q;
    if (load) begin
      pend_data_d = disp_data;
      pend_dp_d   = dp_mask;
      pend_en_d   = digit_en;
    end

    // pend_*_d already carries a coincident load, so it lands in the active set directly.
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    if (wrap) begin
      act_data_d = pend_data_d;
      act_dp_d   = pend_dp_d;
      act_en_d   = pend_en_d;
    end

    done_d = wrap;
  end

  always_comb begin
    nibble = act_data_q[{idx_q, 2'b00} +: 4];
    seg7   = 7'h00;
    unique case (nibble)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      4'hF: seg7 = 7'h71;
    endcase
  end

  // Outputs lag the index by one cycle, so blanking is judged on the pre-edge count.
  always_comb begin
`ifdef SEG_SCAN_BLANK_EN
    blank = (32'(cnt_q) + 32'd1 <= BLANK_CYC);
`else
    blank = 1'b0;
`endif
    if (blank || !act_en_q[idx_q]) begin
      led_d = 8'hFF;
      sel_d = 4'hF;
    end else begin
      led_d = ~{act_dp_q[idx_q], seg7};
      sel_d = ~(4'b0001 << idx_q);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pend_data_q <= 16'h0000;
      pend_dp_q   <= 4'h0;
      pend_en_q   <= 4'h0;
      act_data_q  <= 16'h0000;
      act_dp_q    <= 4'h0;
      act_en_q    <= 4'h0;
      led_q       <= 8'hFF;
      sel_q       <= 4'hF;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_en_q   <= pend_en_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_en_q    <= act_en_d;
      led_q       <= led_d;
      sel_q       <= sel_d;
      done_q      <= done_d;
    end
  end

  assign seg_led    = led_q;
  assign seg_sel    = sel_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (CLK_DIV=4, BLANK_CYC=1); follows SEG_SCAN_BLANK_EN
// the same way the design does.
module tb_seg_scan_ctrl;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned BLANK_CYC = 1;
  localparam int unsigned FRAME     = 4 * CLK_DIV;
`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct packed {
    logic [7:0] led;
    logic [3:0] sel;
    logic       fd;
  } exp_t;

  localparam exp_t DARK = '{led: 8'hFF, sel: 4'hF, fd: 1'b0};

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] disp_data = 16'h0000;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [7:0]  seg_led;
  logic [3:0]  seg_sel;
  logic        frame_done;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  seg_scan_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load       (load),
    .disp_data  (disp_data),
    .dp_mask    (dp_mask),
    .digit_en   (digit_en),
    .seg_led    (seg_led),
    .seg_sel    (seg_sel),
    .frame_done (frame_done)
  );

  always #5 HCLK = ~HCLK;

  // Reference model: k counts clock edges since reset release; slot and frame follow by division.
  initial begin
    int unsigned k, slot, pos;
    logic [15:0] pd, ad;
    logic [3:0]  pp, ap, pe, ae, nib;
    exp_t        e;
    k = 0; pd = '0; ad = '0; pp = '0; ap = '0; pe = '0; ae = '0;
    forever begin
      @(posedge HCLK);
      if (!HRESETn) begin
        k = 0; pd = '0; ad = '0; pp = '0; ap = '0; pe = '0; ae = '0;
        exp_q.push_back(DARK);
      end else begin
        slot = (k / CLK_DIV) % 4;
        pos  = k % CLK_DIV;
        nib  = 4'(ad >> (4 * slot));
        if ((BLANK_EN && pos < BLANK_CYC) || !ae[slot]) begin
          e = DARK;
        end else begin
          e.led = ~{ap[slot], HEX7[nib]};
          e.sel = ~(4'b0001 << slot);
        end
        k++;
        if (load) begin
          pd = disp_data; pp = dp_mask; pe = digit_en;
        end
        if (k % FRAME == 0) begin
          ad = pd; ap = pp; ae = pe;
        end
        e.fd = (k % FRAME == 0);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: one expected vector per clock, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL underflow t=%0t: no expected vector queued", $time);
      end else begin
        e = exp_q.pop_front();
        if (!HRESETn) e = DARK;
        if ({seg_led, seg_sel, frame_done} !== e) begin
          miscompares++;
          $display("FAIL scan t=%0t: got led=%h sel=%b fd=%b, want led=%h sel=%b fd=%b",
                   $time, seg_led, seg_sel, frame_done, e.led, e.sel, e.fd);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #2;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    disp_data = d;
    dp_mask   = dp;
    digit_en  = en;
    load      = 1'b1;
    step(1);
    load      = 1'b0;
    disp_data = 16'($urandom);
    dp_mask   = 4'($urandom);
    digit_en  = 4'($urandom);
  endtask

  initial begin
    step(3);
    HRESETn = 1'b1;                       // k = 0
    step(2);                              // k = 2
    do_load(16'h1234, 4'h0, 4'hF);        // k = 3
    step(40);                             // k = 43
    do_load(16'h1234, 4'h0, 4'b0101);     // k = 44
    step(42);                             // k = 86
    do_load(16'hFFFF, 4'h0, 4'hF);        // sampled at k = 87, digit 1 on display
    step(40);                             // k = 127
    do_load(16'h5678, 4'hA, 4'hF);        // sampled at k = 128, a frame boundary
    step(40);
    do_load(16'h0008, 4'b0001, 4'b0001);
    step(40);

    repeat (2500) begin
      if ($urandom_range(7) == 0) do_load(16'($urandom), 4'($urandom), 4'($urandom));
      else step(1);
    end

    // Reset at digit 2 with fresh data still pending.
    step(1);
    HRESETn = 1'b0;
    step(2);
    HRESETn = 1'b1;                       // k = 0
    do_load(16'h4321, 4'h0, 4'hF);        // k = 1
    step(23);                             // k = 24
    do_load(16'hBEEF, 4'hF, 4'hF);        // k = 25
    step(1);                              // k = 26, digit 2 lit
    HRESETn = 1'b0;
    #1;
    vectors++;
    if ({seg_led, seg_sel, frame_done} !== DARK) begin
      miscompares++;
      $display("FAIL async_reset: got led=%h sel=%b fd=%b, want led=ff sel=1111 fd=0",
               seg_led, seg_sel, frame_done);
    end
    step(2);
    HRESETn = 1'b1;
    step(48);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 50000, HCLK cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLANK_CYC, default 16, blanking cycles at the start of each digit slot; legal range 0..CLK_DIV-1.
REQ-003 HCLK  input  1  clock; all logic is on the rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  update strobe; when high, disp_data, dp_mask and digit_en are captured.
REQ-006 disp_data  input  16  four hex nibbles; digit n displays disp_data[4n+3:4n].
REQ-007 dp_mask  input  4  decimal point per digit; 1 = on.
REQ-008 digit_en  input  4  digit enable per digit; 0 = digit dark.
REQ-009 seg_led  output  8  segments, active-low; bit7 = dp, bits6..0 = g..a.
REQ-010 seg_sel  output  4  digit select, one-hot, active-low.
REQ-011 frame_done  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-012 Prescaler SHALL count 0..CLK_DIV-1, wrap to 0, and assert internal tick in the cycle where count = CLK_DIV-1.
REQ-013 Digit index SHALL advance 0->1->2->3->0, once per tick.
REQ-014 frame_done SHALL be high for exactly the one cycle after the tick that moves the index from 3 to 0.
REQ-015 A load SHALL write the inputs into pending registers; a later load before the frame boundary overwrites them.
REQ-016 Pending values SHALL copy into the active registers on the 3->0 index transition only, so no frame mixes old and new data.
REQ-017 If load coincides with the 3->0 transition, the load inputs SHALL go directly into the active registers.
REQ-018 The display SHALL use only the active registers.
REQ-019 Hex decode (gfedcba, active-high before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 For an enabled digit: seg_led = ~{dp_mask_act[idx], decode(nibble[idx])} and seg_sel = ~(4'b0001 << idx).
REQ-021 For a disabled digit: seg_sel = 4'hF and seg_led = 8'hFF.
REQ-022 seg_led and seg_sel SHALL be registered and SHALL change one HCLK after the index changes.
REQ-023 No HCLK cycle SHALL ever have more than one seg_sel bit low.

Reset
REQ-024 While HRESETn is low, all of the following SHALL apply immediately (asynchronously): prescaler = 0, index = 0, pending and active registers = 0 (including digit_en = 0), seg_sel = 4'hF, seg_led = 8'hFF, frame_done = 0.
REQ-025 Reset asserted mid-scan SHALL discard pending data.
REQ-026 After reset release, scanning SHALL restart from digit 0 with a full CLK_DIV slot, and the display SHALL stay dark until a load reaches the active registers.

Configuration
REQ-027 Macro SEG_SCAN_BLANK_EN defined: for the first BLANK_CYC cycles of every digit slot, outputs SHALL be seg_sel = 4'hF and seg_led = 8'hFF (ghosting suppression); BLANK_CYC = 0 means no blanking.
REQ-028 Macro SEG_SCAN_BLANK_EN undefined: the blanking logic SHALL be absent, BLANK_CYC SHALL be ignored, and the digit drives for the whole slot.

Verification (CLK_DIV=4, BLANK_CYC=1)
REQ-029 load 16'h1234, dp 0, en 4'hF; wait for frame_done -> digit0: seg_sel 4'b1110, seg_led 8'h99; digit1: seg_sel 4'b1101, seg_led 8'hB0.
REQ-030 en 4'b0101 -> digits 1 and 3 give seg_sel 4'hF, seg_led 8'hFF; digits 0 and 2 light normally.
REQ-031 load 16'hFFFF while digit 1 is displayed -> digits 1..3 of the current frame keep old data; 8'h8E is seen only after the next frame_done.
REQ-032 dp_mask 4'b0001, nibble0 = 8 -> digit0 seg_led = 8'h00.
REQ-033 SEG_SCAN_BLANK_EN defined -> first cycle of each slot gives seg_sel 4'hF; undefined -> no blank cycle.
REQ-034 HRESETn low mid-slot at digit 2 -> seg_sel 4'hF and seg_led 8'hFF the same cycle; after release, frame_done occurs 16 cycles later.
